// File: rtl/reg_dump_pkg.sv
// Shared defaults and FSM state encoding for the register dump reader.
package reg_dump_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;
  localparam int NUM_DEF        = 1 << ADDR_WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    CSUM
  } state_t;

endpackage

// File: rtl/reg_dump_csum.sv
// XOR accumulator over the data beats of one dump; exists only in REG_DUMP_CSUM_EN builds.
`ifdef REG_DUMP_CSUM_EN
module reg_dump_csum
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        value <= '0;
    else if (clear)  value <= '0;
    else if (enable) value <= value ^ data;
  end

endmodule
`endif

// File: rtl/reg_dump_reader.sv
// Streams register-file words first..last (wrapping) as valid/ready beats.
// REG_DUMP_CSUM_EN adds an XOR checksum trailer beat after the data beats.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | first word on rdata, loading the first beat
// SEND  | beat presented; each handshake reloads the next word
// CSUM  | checksum trailer beat presented
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM        = NUM_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  out_csum,
  output logic                  busy,
  output logic                  done
);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n, ptr_inc, last_q, last_n, addr_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  valid_n, olast_n, done_n, load, hshake;

  assign ptr_inc = (ptr == ADDR_WIDTH'(NUM - 1)) ? '0 : ptr + 1'b1;
  assign hshake  = out_valid && out_ready;
  assign raddr   = ptr;
  assign busy    = (state != IDLE);

`ifdef REG_DUMP_CSUM_EN
  logic                  csum_clr, csum_q, csum_n;
  logic [DATA_WIDTH-1:0] csum_value;

  reg_dump_csum #(.DATA_WIDTH(DATA_WIDTH)) u_csum (
    .clk    (clk),
    .rst    (rst),
    .clear  (csum_clr),
    .enable (load),
    .data   (rdata),
    .value  (csum_value)
  );

  assign out_csum = csum_q;
`else
  assign out_csum = 1'b0;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    last_n  = last_q;
    valid_n = out_valid;
    data_n  = out_data;
    addr_n  = out_addr;
    olast_n = out_last;
    done_n  = 1'b0;
    load    = 1'b0;
`ifdef REG_DUMP_CSUM_EN
    csum_clr = 1'b0;
    csum_n   = csum_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          ptr_n   = first_addr;
          last_n  = last_addr;
          state_n = FETCH;
`ifdef REG_DUMP_CSUM_EN
          csum_clr = 1'b1;
`endif
        end
      end
      FETCH: begin
        load    = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        if (hshake) begin
          if (out_addr == last_q) begin
`ifdef REG_DUMP_CSUM_EN
            // accumulator already holds every data word, loaded at each fetch
            data_n  = csum_value;
            addr_n  = '0;
            olast_n = 1'b1;
            csum_n  = 1'b1;
            state_n = CSUM;
`else
            valid_n = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
`endif
          end else begin
            load = 1'b1;
          end
        end
      end
      CSUM: begin
`ifdef REG_DUMP_CSUM_EN
        if (hshake) begin
          valid_n = 1'b0;
          olast_n = 1'b0;
          csum_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
`else
        state_n = IDLE;
`endif
      end
      default: state_n = IDLE;
    endcase

    if (load) begin
      data_n  = rdata;
      addr_n  = ptr;
      valid_n = 1'b1;
      ptr_n   = ptr_inc;
`ifdef REG_DUMP_CSUM_EN
      olast_n = 1'b0;
`else
      olast_n = (ptr == last_q);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      last_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
      csum_q    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      last_q    <= last_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      out_addr  <= addr_n;
      out_last  <= olast_n;
      done      <= done_n;
`ifdef REG_DUMP_CSUM_EN
      csum_q    <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: table of dumps with a beat scoreboard,
// plus reset-mid-dump and initial reset sequences. Adapts to REG_DUMP_CSUM_EN.
module tb_reg_dump_reader;

`ifdef REG_DUMP_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk, rst, start, out_valid, out_ready, out_last, out_csum, busy, done;
  logic [4:0]  first_addr, last_addr, raddr, out_addr;
  logic [31:0] rdata, out_data;
  logic [31:0] rf [32];

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        last;
    logic        csum;
  } beat_t;

  typedef struct {
    logic [4:0] first;
    logic [4:0] last;
    logic [3:0] mask;
    bit         glitch;
    int         beats;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[6];
  int    checks = 0;
  int    errors = 0;

  reg_dump_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .raddr      (raddr),
    .rdata      (rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .out_csum   (out_csum),
    .busy       (busy),
    .done       (done)
  );

  assign rdata = rf[raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_dump(input vec_t v);
    int          cyc, acc, last_acc, final_cyc;
    bit          stalled, got_done;
    beat_t       held, exp;
    logic [4:0]  a;
    logic [31:0] x;

    a = v.first;
    x = '0;
    for (int k = 0; k < 32; k++) begin
      sb.push_back('{addr: a, data: rf[a], last: (a == v.last) && !CSUM_ON, csum: 1'b0});
      x ^= rf[a];
      if (a == v.last) break;
      a = a + 5'd1;
    end
    if (CSUM_ON) sb.push_back('{addr: 5'd0, data: x, last: 1'b1, csum: 1'b1});

    @(negedge clk);
    start = 1'b1; first_addr = v.first; last_addr = v.last; out_ready = v.mask[0];
    cyc = 0; acc = 0; last_acc = 0; final_cyc = -10; stalled = 1'b0; got_done = 1'b0;
    held = '0;
    while (cyc < 300 && !got_done) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (v.glitch && cyc == 5) begin start = 1'b1; first_addr = 5'd20; last_addr = 5'd22; end
      if (v.glitch && cyc == 6) start = 1'b0;
      out_ready = v.mask[2'(cyc)];
      if (cyc == 1) chk("fetch_no_valid", {63'd0, out_valid}, 64'd0);
      if (cyc == 2) chk("first_beat_latency", {63'd0, out_valid}, 64'd1);
      if (stalled) begin
        chk("stall_data", {32'd0, out_data}, {32'd0, held.data});
        chk("stall_addr", {59'd0, out_addr}, {59'd0, held.addr});
        chk("stall_last_valid", {62'd0, out_last, out_valid}, {62'd0, held.last, 1'b1});
      end
      if (done) begin
        got_done = 1'b1;
        chk("done_timing", 64'(cyc), 64'(final_cyc + 1));
        chk("busy_at_done", {63'd0, busy}, 64'd0);
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_beat: got addr %0h data %0h expected no beat", out_addr, out_data);
        end else begin
          exp = sb.pop_front();
          chk("beat_addr", {59'd0, out_addr}, {59'd0, exp.addr});
          chk("beat_data", {32'd0, out_data}, {32'd0, exp.data});
          chk("beat_last", {63'd0, out_last}, {63'd0, exp.last});
          chk("beat_csum", {63'd0, out_csum}, {63'd0, exp.csum});
        end
        if (v.mask == 4'hF && acc > 0) chk("beat_gap", 64'(cyc - last_acc), 64'd1);
        acc++;
        last_acc = cyc;
        if (sb.size() == 0) final_cyc = cyc;
      end
      stalled = out_valid && !out_ready && !done;
      held    = '{addr: out_addr, data: out_data, last: out_last, csum: out_csum};
    end
    if (!got_done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", cyc);
    end
    chk("beat_count", 64'(acc), 64'(v.beats + int'(CSUM_ON)));
    chk("sb_empty", 64'(sb.size()), 64'd0);
    sb.delete();
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{5'd3,  5'd5,  4'hF,    1'b0, 3};
    vecs[1] = '{5'd30, 5'd1,  4'hF,    1'b0, 4};
    vecs[2] = '{5'd7,  5'd7,  4'hF,    1'b0, 1};
    vecs[3] = '{5'd10, 5'd12, 4'b1001, 1'b0, 3};
    vecs[4] = '{5'd31, 5'd0,  4'hF,    1'b0, 2};
    vecs[5] = '{5'd0,  5'd31, 4'b1011, 1'b1, 32};

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[7] = 32'hA5A5A5A5;

    rst = 1'b0; start = 1'b0; out_ready = 1'b0; first_addr = '0; last_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {out_valid, out_last, out_csum, busy, done, out_addr, raddr, out_data},
        64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("after_release_idle", {63'd0, busy | done | out_valid}, 64'd0);

    for (int i = 0; i < 6; i++) run_dump(vecs[i]);

    // reset while the second beat of a full dump is presented
    @(negedge clk);
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd31; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rst_seq_first_beat", {59'd0, out_addr}, 64'd0);
    @(negedge clk);
    chk("rst_seq_second_beat", {59'd0, out_addr}, 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_async_ctrl", {59'd0, out_valid, out_last, out_csum, busy, done}, 64'd0);
    chk("rst_async_data", {27'd0, out_addr, raddr, out_data}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_rst", {62'd0, done, busy}, 64'd0);
    end
    run_dump('{5'd2, 5'd2, 4'hF, 1'b0, 1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, register word width; ADDR_WIDTH, default 5, register index width; NUM, default 32, register count (2**ADDR_WIDTH).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle dump request; sampled only in IDLE.
REQ-005 SHALL have port first_addr  input  ADDR_WIDTH  first register index to dump; sampled with start.
REQ-006 SHALL have port last_addr  input  ADDR_WIDTH  last register index to dump; sampled with start.
REQ-007 SHALL have port raddr  output  ADDR_WIDTH  read address to the register file read port.
REQ-008 SHALL have port rdata  input  DATA_WIDTH  combinational read data for raddr, same cycle.
REQ-009 SHALL have port out_valid  output  1  stream beat valid.
REQ-010 SHALL have port out_ready  input  1  downstream accept.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  beat payload.
REQ-012 SHALL have port out_addr  output  ADDR_WIDTH  register index of beat (0 on checksum beat).
REQ-013 SHALL have port out_last  output  1  final beat of dump.
REQ-014 SHALL have port out_csum  output  1  beat carries checksum.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after final beat accepted.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, SEND, CSUM; internal pointer ptr (ADDR_WIDTH) drives raddr directly.
REQ-018 IDLE + start: ptr<=first_addr, latch last_addr, clear checksum, go FETCH; start outside IDLE SHALL be ignored.
REQ-019 FETCH: out_data<=rdata, out_addr<=ptr, out_last<=(ptr==last, and checksum disabled), out_valid<=1, ptr<=ptr+1, go SEND.
REQ-020 SHALL hold out_data/out_addr/out_last/out_valid stable while out_valid && !out_ready.
REQ-021 SEND on handshake, not final data beat: reload from rdata at ptr per REQ-019 in the same edge, stay SEND (one beat/cycle after 1-cycle startup latency).
REQ-022 SEND on handshake of final data beat: go CSUM if checksum enabled, else out_valid<=0, done<=1, go IDLE.
REQ-023 ptr SHALL wrap modulo NUM; first_addr>last_addr dumps first..NUM-1 then 0..last (e.g. 30,31,0,1).
REQ-024 first_addr==last_addr SHALL produce exactly one data beat.
REQ-025 Each word SHALL be sampled at its load edge; no snapshot consistency against concurrent register writes.
REQ-026 done SHALL be high exactly one cycle, the cycle after the final handshake; busy low that same cycle.

Reset
REQ-027 rst low SHALL immediately force IDLE, ptr=0, raddr=0, out_valid=0, out_data=0, out_addr=0, out_last=0, out_csum=0, done=0, checksum=0.
REQ-028 Reset mid-dump SHALL abandon the dump with no done pulse; next start after release begins a fresh dump.

Configuration
REQ-029 Macro REG_DUMP_CSUM_EN defined: checksum = XOR of all data beats of the dump; CSUM state presents out_data=checksum, out_addr=0, out_csum=1, out_last=1; on handshake done<=1, go IDLE; data beats carry out_last=0.
REQ-030 Macro undefined: no CSUM state, no checksum register, out_csum tied 0, out_last on final data beat.

Structure
REQ-031 Package reg_dump_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH/NUM defaults and the FSM state enum typedef.
REQ-032 Sub-module reg_dump_csum (XOR accumulator: clear, enable, data, value) SHALL be instantiated only under REG_DUMP_CSUM_EN.

Verification
REQ-033 RF preloaded r[i]=0x1000+i, first=3, last=5, out_ready=1 -> beats addr 3,4,5 data 0x1003..0x1005 on consecutive cycles, last on addr 5, done next cycle.
REQ-034 first=30, last=1 -> addr sequence 30,31,0,1; out_last only on 1.
REQ-035 out_ready toggled 1,0,0,1 during dump -> payload held stable while stalled, no beat lost or duplicated.
REQ-036 CSUM_EN, first=last=7, r7=0xA5A5A5A5 -> data beat 0xA5A5A5A5, then checksum beat 0xA5A5A5A5 with out_csum=1, out_last=1.
REQ-037 rst low during second beat of 0..31 dump -> outputs zero at once, no done; new start 2..2 yields one beat addr 2.
REQ-038 start pulsed while busy -> ignored; in-flight dump completes unchanged.
